// File: rtl/nmi_xbar.sv
// nmi_xbar: round-robin multi-master to address-windowed multi-slave NMI interconnect with decode error and timeout
module nmi_xbar #(
  parameter int NUM_MST = 2,
  parameter int NUM_SLV = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK = {4{32'hF000_0000}},
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_MST-1:0]   mst_valid_i,
  input  logic [NUM_MST*32-1:0] mst_addr_i,
  input  logic [NUM_MST*32-1:0] mst_wdata_i,
  input  logic [NUM_MST*4-1:0] mst_wstrb_i,
  output logic [NUM_MST*32-1:0] mst_rdata_o,
  output logic [NUM_MST-1:0]   mst_ready_o,
  output logic [NUM_SLV-1:0]   slv_valid_o,
  output logic [31:0]          slv_addr_o,
  output logic [31:0]          slv_wdata_o,
  output logic [3:0]           slv_wstrb_o,
  input  logic [NUM_SLV*32-1:0] slv_rdata_i,
  input  logic [NUM_SLV-1:0]   slv_ready_i,
  output logic                 err_irq_o,
  output logic [31:0]          err_addr_o
);
  localparam int MW = NUM_MST > 1 ? $clog2(NUM_MST) : 1;
  localparam int SW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state, state_nxt;
  logic [MW-1:0] gnt, last, gnt_nxt;
  logic [SW-1:0] sel, sel_nxt;
  logic [CW-1:0] cnt;
  logic req, hit, rdy, tmo, abort;
  logic [31:0] req_addr, cur_addr;
  assign cur_addr = mst_addr_i[gnt*32 +: 32];
  assign rdy = slv_ready_i[sel];
  assign abort = state == BUSY && !mst_valid_i[gnt];
  assign tmo = state == BUSY && mst_valid_i[gnt] && !rdy && TIMEOUT != 0 && int'(cnt) + 1 >= TIMEOUT;
  // Round-robin pick starting after the last grant, then lowest-index window match
  always_comb begin
    gnt_nxt = '0;
    req = 1'b0;
    for (int i = NUM_MST; i >= 1; i--)
      if (mst_valid_i[MW'((int'(last) + i) % NUM_MST)]) begin
        gnt_nxt = MW'((int'(last) + i) % NUM_MST);
        req = 1'b1;
      end
    req_addr = mst_addr_i[gnt_nxt*32 +: 32];
    sel_nxt = '0;
    hit = 1'b0;
    for (int k = NUM_SLV - 1; k >= 0; k--)
      if ((req_addr & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) begin
        sel_nxt = SW'(k);
        hit = 1'b1;
      end
  end
  // Next state plus the shared slave bus mux and master response pass-through
  always_comb begin
    state_nxt = state;
    mst_ready_o = '0;
    mst_rdata_o = '0;
    slv_addr_o = '0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    case (state)
      IDLE: state_nxt = req ? (hit ? BUSY : ERR) : IDLE;
      BUSY: begin
        slv_addr_o = cur_addr;
        slv_wdata_o = mst_wdata_i[gnt*32 +: 32];
        slv_wstrb_o = mst_wstrb_i[gnt*4 +: 4];
        mst_rdata_o[gnt*32 +: 32] = tmo ? ERR_RDATA : slv_rdata_i[sel*32 +: 32];
        mst_ready_o[gnt] = !abort && (rdy || tmo);
        state_nxt = abort || rdy || tmo ? IDLE : BUSY;
      end
      ERR: begin
        mst_rdata_o[gnt*32 +: 32] = ERR_RDATA;
        mst_ready_o[gnt] = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_nxt;
  // Grant bookkeeping, saturating timeout counter and registered slave/error outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt <= '0;
      last <= MW'(NUM_MST - 1);
      sel <= '0;
      cnt <= '0;
      slv_valid_o <= '0;
      err_irq_o <= 1'b0;
      err_addr_o <= '0;
    end else begin
      err_irq_o <= state == ERR || tmo;
      if (state == ERR || tmo) err_addr_o <= cur_addr;
      if (state == IDLE && req) begin
        gnt <= gnt_nxt;
        last <= gnt_nxt;
        sel <= sel_nxt;
        cnt <= '0;
        slv_valid_o <= hit ? NUM_SLV'(1) << sel_nxt : '0;
      end else if (state == BUSY) begin
        cnt <= int'(cnt) >= TIMEOUT ? cnt : cnt + 1'b1;
        slv_valid_o <= state_nxt == BUSY ? slv_valid_o : '0;
      end
    end
  end
endmodule

// File: tb/tb_nmi_xbar.sv
// tb_nmi_xbar: directed scoreboard bench for nmi_xbar
module tb_nmi_xbar;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] mst_valid_i = '0;
  logic [63:0] mst_addr_i = '0;
  logic [63:0] mst_wdata_i = '0;
  logic [7:0] mst_wstrb_i = '0;
  logic [63:0] mst_rdata_o;
  logic [1:0] mst_ready_o;
  logic [3:0] slv_valid_o;
  logic [31:0] slv_addr_o, slv_wdata_o;
  logic [3:0] slv_wstrb_o;
  logic [127:0] slv_rdata_i = {32'hA000_0003, 32'hA000_0002, 32'h1234_5678, 32'hA000_0000};
  logic [3:0] slv_ready_i = '0;
  logic err_irq_o;
  logic [31:0] err_addr_o;
  typedef struct packed {logic [7:0] m; logic [31:0] d;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_assert = 0, n_fail = 0, irq_cnt = 0, base = 0;
  int ct_v[7] = '{1, 0, 4, 0, 1, 0, 4};
  int ct_r[7] = '{1, 0, 2, 0, 1, 0, 2};

  nmi_xbar #(
    .NUM_MST(2), .NUM_SLV(4),
    .SLV_MASK({32'hFFFF_0000, {3{32'hF000_0000}}}),
    .TIMEOUT(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mst_valid_i(mst_valid_i), .mst_addr_i(mst_addr_i), .mst_wdata_i(mst_wdata_i), .mst_wstrb_i(mst_wstrb_i),
    .mst_rdata_o(mst_rdata_o), .mst_ready_o(mst_ready_o),
    .slv_valid_o(slv_valid_o), .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o), .slv_wstrb_o(slv_wstrb_o),
    .slv_rdata_i(slv_rdata_i), .slv_ready_i(slv_ready_i),
    .err_irq_o(err_irq_o), .err_addr_o(err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // Scoreboard: every master ready must match the oldest expected response
  always @(negedge clk_i) begin
    if (err_irq_o === 1'b1) irq_cnt++;
    for (int m = 0; m < 2; m++)
      if (mst_ready_o[m] === 1'b1) begin
        if (sb.size() == 0) check("unexpected_ready", 32'(m), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          check("ready_master", 32'(m), 32'(e.m));
          check("ready_rdata", mst_rdata_o[m*32 +: 32], e.d);
        end
      end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drv();
    drv();
    rst_i = 1'b0;
    smp();
    check("rst_slv_valid", 32'(slv_valid_o), 0);
    check("rst_mst_ready", 32'(mst_ready_o), 0);
    check("rst_rdata0", mst_rdata_o[31:0], 0);
    check("rst_rdata1", mst_rdata_o[63:32], 0);
    check("rst_irq", 32'(err_irq_o), 0);
    check("rst_err_addr", err_addr_o, 0);
    check("rst_slv_addr", slv_addr_o, 0);
    check("rst_slv_wdata", slv_wdata_o, 0);
    check("rst_slv_wstrb", 32'(slv_wstrb_o), 0);

    drv();
    mst_valid_i = 2'b01;
    mst_addr_i[31:0] = 32'h1000_0040;
    sb.push_back('{m: 8'd0, d: 32'h1234_5678});
    smp();
    check("rd_idle", 32'(slv_valid_o), 0);
    for (int i = 0; i < 3; i++) begin
      drv();
      if (i == 2) slv_ready_i = 4'b0010;
      smp();
      check("rd_valid", 32'(slv_valid_o), 32'h2);
      check("rd_addr", slv_addr_o, 32'h1000_0040);
      check("rd_ready", 32'(mst_ready_o), i == 2 ? 1 : 0);
    end
    drv();
    mst_valid_i = 2'b00;
    slv_ready_i = 4'b0000;
    smp();
    check("rd_done", 32'(slv_valid_o), 0);
    check("rd_no_irq", 32'(irq_cnt), 0);

    drv();
    rst_i = 1'b1;
    drv();
    rst_i = 1'b0;
    mst_addr_i = {32'h2000_0020, 32'h0000_0010};
    mst_valid_i = 2'b11;
    slv_ready_i = 4'hF;
    for (int i = 0; i < 4; i++) sb.push_back('{m: 8'(i % 2), d: (i % 2) == 0 ? 32'hA000_0000 : 32'hA000_0002});
    for (int i = 0; i < 7; i++) begin
      drv();
      if (i == 6) mst_valid_i = 2'b10;
      smp();
      check("rr_valid", 32'(slv_valid_o), 32'(ct_v[i]));
      check("rr_ready", 32'(mst_ready_o), 32'(ct_r[i]));
    end
    drv();
    mst_valid_i = 2'b00;
    slv_ready_i = 4'h0;
    smp();
    check("rr_done", 32'(slv_valid_o), 0);

    drv();
    base = irq_cnt;
    mst_valid_i = 2'b01;
    mst_addr_i[31:0] = 32'h3001_0000;
    mst_wdata_i[31:0] = 32'h5555_AAAA;
    mst_wstrb_i[3:0] = 4'hF;
    sb.push_back('{m: 8'd0, d: 32'hDEAD_BEEF});
    smp();
    drv();
    smp();
    check("dec_no_slave", 32'(slv_valid_o), 0);
    check("dec_ready", 32'(mst_ready_o), 1);
    drv();
    mst_valid_i = 2'b00;
    smp();
    check("dec_irq", 32'(err_irq_o), 1);
    check("dec_err_addr", err_addr_o, 32'h3001_0000);
    check("dec_ready_off", 32'(mst_ready_o), 0);
    drv();
    smp();
    check("dec_irq_once", 32'(irq_cnt - base), 1);

    drv();
    base = irq_cnt;
    mst_valid_i = 2'b10;
    mst_addr_i[63:32] = 32'h2000_0000;
    mst_wstrb_i[7:4] = 4'h0;
    sb.push_back('{m: 8'd1, d: 32'hDEAD_BEEF});
    smp();
    for (int i = 0; i < 4; i++) begin
      drv();
      smp();
      check("tmo_valid", 32'(slv_valid_o), 32'h4);
      check("tmo_ready", 32'(mst_ready_o), i == 3 ? 2 : 0);
      check("tmo_irq_low", 32'(err_irq_o), 0);
    end
    drv();
    mst_valid_i = 2'b00;
    smp();
    check("tmo_valid_drop", 32'(slv_valid_o), 0);
    check("tmo_irq", 32'(err_irq_o), 1);
    check("tmo_err_addr", err_addr_o, 32'h2000_0000);
    drv();
    smp();
    check("tmo_irq_once", 32'(irq_cnt - base), 1);

    drv();
    mst_valid_i = 2'b10;
    mst_addr_i[63:32] = 32'h2000_0100;
    smp();
    drv();
    smp();
    check("abort_busy", 32'(slv_valid_o), 32'h4);
    drv();
    mst_valid_i = 2'b00;
    smp();
    check("abort_no_ready", 32'(mst_ready_o), 0);
    drv();
    smp();
    check("abort_idle", 32'(slv_valid_o), 0);
    check("abort_no_irq", 32'(err_irq_o), 0);

    drv();
    mst_valid_i = 2'b10;
    mst_addr_i[63:32] = 32'h1000_0000;
    smp();
    drv();
    smp();
    check("mrst_busy", 32'(slv_valid_o), 32'h2);
    drv();
    rst_i = 1'b1;
    smp();
    drv();
    rst_i = 1'b0;
    mst_valid_i = 2'b11;
    mst_addr_i[31:0] = 32'h0000_0000;
    smp();
    check("mrst_valid", 32'(slv_valid_o), 0);
    check("mrst_ready", 32'(mst_ready_o), 0);
    check("mrst_irq", 32'(err_irq_o), 0);
    check("mrst_addr", slv_addr_o, 0);
    check("mrst_rdata1", mst_rdata_o[63:32], 0);
    drv();
    smp();
    check("mrst_regrant_m0", 32'(slv_valid_o), 32'h1);
    drv();
    slv_ready_i = 4'b0001;
    mst_valid_i = 2'b01;
    sb.push_back('{m: 8'd0, d: 32'hA000_0000});
    smp();
    check("mrst_m0_ready", 32'(mst_ready_o), 1);
    drv();
    mst_valid_i = 2'b00;
    slv_ready_i = 4'b0000;
    smp();

    drv();
    mst_valid_i = 2'b01;
    mst_addr_i[31:0] = 32'h0000_0100;
    mst_wdata_i[31:0] = 32'hAABB_CCDD;
    mst_wstrb_i[3:0] = 4'b0101;
    smp();
    drv();
    smp();
    check("wr_valid", 32'(slv_valid_o), 32'h1);
    check("wr_wstrb", 32'(slv_wstrb_o), 32'h5);
    check("wr_wdata", slv_wdata_o, 32'hAABB_CCDD);
    check("wr_addr", slv_addr_o, 32'h0000_0100);
    drv();
    slv_ready_i = 4'b0001;
    sb.push_back('{m: 8'd0, d: 32'hA000_0000});
    smp();
    check("wr_ready", 32'(mst_ready_o), 1);
    check("wr_wstrb_hold", 32'(slv_wstrb_o), 32'h5);
    drv();
    mst_valid_i = 2'b00;
    slv_ready_i = 4'b0000;
    smp();

    drv();
    smp();
    check("sb_empty", 32'(sb.size()), 0);
    check("irq_total", 32'(irq_cnt), 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/nmi_xbar.md
# nmi_xbar

Parametrised native-memory-interface (NMI: valid/addr/wdata/wstrb/rdata/ready) interconnect joining `NUM_MST` masters to `NUM_SLV` address-windowed slaves over one shared transaction path. It provides:
- round-robin arbitration between masters;
- first-match address decoding against per-slave base/mask windows;
- a bus-error response for unmapped addresses;
- a per-transaction timeout that retires hung slave accesses.

It replaces fixed-decode single-master bus glue between core, native peripherals, APB bridge, PSRAM, SPI-SD and cross-clock bridges.

## Interface
Parameters:
- `NUM_MST`, default 2: number of masters, 1..8.
- `NUM_SLV`, default 4: number of slaves, 1..16.
- `SLV_BASE`, default `{32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}`: packed `NUM_SLV*32`; slave k window base in bits `[k*32+:32]`.
- `SLV_MASK`, default `{4{32'hF000_0000}}`: packed `NUM_SLV*32`; slave k hits when `(addr & mask_k) == base_k`.
- `TIMEOUT`, default 255: cycles a slave may hold off ready; 0 disables the timeout.
- `ERR_RDATA`, default `32'hDEAD_BEEF`: rdata returned on decode error or timeout.

Ports:
- `clk_i` in 1: clock. The block runs on one clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `mst_valid_i` in `NUM_MST`: per-master request.
- `mst_addr_i` in `NUM_MST*32`: request address.
- `mst_wdata_i` in `NUM_MST*32`: write data.
- `mst_wstrb_i` in `NUM_MST*4`: byte strobes; 0 means read.
- `mst_rdata_o` out `NUM_MST*32`: read data, valid while the matching ready bit is high.
- `mst_ready_o` out `NUM_MST`: one-cycle completion pulse per master.
- `slv_valid_o` out `NUM_SLV`: one-hot slave request.
- `slv_addr_o` out 32: shared address to all slaves.
- `slv_wdata_o` out 32: shared write data.
- `slv_wstrb_o` out 4: shared strobes.
- `slv_rdata_i` in `NUM_SLV*32`: slave read data.
- `slv_ready_i` in `NUM_SLV`: slave completion.
- `err_irq_o` out 1: one-cycle pulse on decode error or timeout.
- `err_addr_o` out 32: address of the most recent errored transaction.

## Operation
State machine states: IDLE, BUSY, ERR.

IDLE:
- When any `mst_valid_i` bit is high, grant the first requesting master scanning upward from `last+1`, modulo `NUM_MST`.
- Register the grant index, update `last`, and decode the granted master's address.
- Lowest-index matching slave → register it as `sel`, go to BUSY, clear the timeout counter.
- No slave matches → go to ERR.

BUSY:
- `slv_valid_o[sel]` = 1; every other `slv_valid_o` bit = 0.
- `slv_addr_o`, `slv_wdata_o` and `slv_wstrb_o` are muxed combinationally from the granted master.
- The granted master's `mst_rdata_o` = `slv_rdata_i[sel]`; its `mst_ready_o` = `slv_ready_i[sel]`.
- Slave ready → return to IDLE.
- Timeout counter increments each BUSY cycle without ready. When it reaches `TIMEOUT` (and `TIMEOUT` ≠ 0) that cycle:
  - `slv_valid_o` drops;
  - the master gets ready with `ERR_RDATA`;
  - `err_irq_o` pulses and `err_addr_o` captures the address;
  - go to IDLE.
- Granted master drops `mst_valid_i` before ready (protocol violation) → abort to IDLE, no ready, no error flag.

ERR, one cycle:
- Granted master gets ready with `ERR_RDATA`; no slave is selected.
- `err_irq_o` pulses and `err_addr_o` captures the address.
- Go to IDLE.

General rules:
- Non-granted masters see `mst_ready_o` = 0 and `mst_rdata_o` = 0.
- Simultaneous requests are resolved purely by the round-robin pointer. A waiting master is served within `NUM_MST` transactions.
- Ignored during BUSY/ERR: any `slv_ready_i` bit other than `sel`, and any new master requests.
- Timeout counter width is `$clog2(TIMEOUT+1)` and saturates; it never wraps.
- `NUM_MST` = 1 degenerates to a fixed grant.

## Timing
- Reset values:
  - state IDLE, `last` = `NUM_MST-1` (so master 0 wins first);
  - all `slv_valid_o`, `mst_ready_o` and `err_irq_o` bits 0;
  - `mst_rdata_o` 0, `slv_*` data/address 0, `err_addr_o` 0, counter 0.
- Reset asserted mid-transaction: state returns to IDLE on the next edge, `slv_valid_o` deasserts, and no ready is issued.
- Arbitration latency: request seen in cycle n → `slv_valid_o` high in cycle n+1.
- Ready path: slave ready in cycle n+1 → master ready in cycle n+1 (combinational pass-through).
- Throughput: minimum one transaction per 2 cycles; the IDLE cycle is mandatory between transactions.
- Decode error: master ready in cycle n+1.
- Timeout: master ready in cycle n+`TIMEOUT`.
- Registered outputs: `slv_valid_o`, `err_irq_o`, `err_addr_o`.
- The ready/rdata pass-through is the only combinational slave→master path.

## Test plan
- **Single master, slave 1 read:** master 0 reads `0x1000_0040`; slave 1 returns `0x1234_5678` with ready 3 cycles later → `slv_valid_o` = `4'b0010` for 3 cycles, then master 0 gets ready with `0x1234_5678`; `err_irq_o` stays 0.
- **Contention:** masters 0 and 1 both hold valid after reset; slaves answer ready immediately → grant order 0,1,0,1; each master completes one transaction per 4 cycles.
- **Unmapped address:** with `SLV_MASK` entry 3 = `32'hFFFF_0000`, a write to `0x3001_0000` → no `slv_valid_o`; master gets ready with `0xDEAD_BEEF` in cycle n+1; `err_irq_o` pulses once; `err_addr_o` = `0x3001_0000`.
- **Timeout:** `TIMEOUT` = 4 and slave 2 never readies → `slv_valid_o[2]` high for cycles n+1..n+4; ready with `ERR_RDATA` at n+4; `err_irq_o` pulses.
- **Reset mid-BUSY:** assert `rst_i` for 1 cycle → all outputs 0 next cycle; the next request is granted to master 0.
- **Write strobes:** a write with `wstrb` = `4'b0101` and wdata `0xAABB_CCDD` to slave 0 → `slv_wstrb_o`/`slv_wdata_o` match exactly while `slv_valid_o[0]` = 1.
